// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: shared CPU control encodings and defaults
package pipeline_ctrl_pkg;
    localparam int RBITS_DEF = 5;
    localparam int CBITS_DEF = 32;
    localparam int DRAIN_LEN = 3;
    typedef enum logic [2:0] {IDLE, RUN, STEP, DRAIN, HALTED} state_t;
endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// hazard_detect: load-use comparison between the EX load and the ID sources
module hazard_detect
    import pipeline_ctrl_pkg::*;
#(
    parameter int RBITS = RBITS_DEF
) (
    input  logic             ex_memread,
    input  logic [RBITS-1:0] ex_rt,
    input  logic [RBITS-1:0] id_rs,
    input  logic [RBITS-1:0] id_rt,
    output logic             hazard
);
    always_comb hazard = ex_memread && (ex_rt != '0) && (ex_rt == id_rs || ex_rt == id_rt);
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: run/step/drain sequencing of pipeline enables and flushes with performance counters
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int RBITS = RBITS_DEF,
    parameter int CBITS = CBITS_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_mode,
    input  logic             i_step,
    input  logic [RBITS-1:0] ID_rs,
    input  logic [RBITS-1:0] ID_rt,
    input  logic [RBITS-1:0] EX_rt,
    input  logic             EX_memread,
    input  logic             EX_branch_taken,
    input  logic             ID_halt,
    output logic             o_pc_en,
    output logic             o_ifid_en,
    output logic             o_idex_en,
    output logic             o_exmem_en,
    output logic             o_memwb_en,
    output logic             o_ifid_flush,
    output logic             o_idex_flush,
    output logic             o_halted,
    output logic [CBITS-1:0] o_cycle_cnt,
    output logic [CBITS-1:0] o_stall_cnt
);
    state_t     state;
    logic [1:0] drain_cnt;
    logic       load_use, stall, halt_ok, active, drain;

    hazard_detect #(.RBITS(RBITS)) u_hazard (
        .ex_memread(EX_memread),
        .ex_rt(EX_rt),
        .id_rs(ID_rs),
        .id_rt(ID_rt),
        .hazard(load_use)
    );

    // a taken branch squashes both the stall and any HALT sitting in ID
    always_comb begin
        active = (state == RUN || state == STEP) && !i_rst;
        drain = state == DRAIN && !i_rst;
        stall = load_use && !EX_branch_taken;
        halt_ok = ID_halt && !load_use && !EX_branch_taken;
        o_pc_en = active && !stall && !halt_ok;
        o_ifid_en = active && !stall;
        o_idex_en = active || drain;
        o_exmem_en = active || drain;
        o_memwb_en = active || drain;
        o_ifid_flush = active && (EX_branch_taken || halt_ok);
        o_idex_flush = active && (EX_branch_taken || load_use);
        o_halted = state == HALTED && !i_rst;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
            drain_cnt <= '0;
            o_cycle_cnt <= '0;
            o_stall_cnt <= '0;
        end else begin
            if ((active || drain) && !(&o_cycle_cnt)) o_cycle_cnt <= o_cycle_cnt + CBITS'(1);
            if (active && stall && !(&o_stall_cnt)) o_stall_cnt <= o_stall_cnt + CBITS'(1);
            case (state)
                IDLE: state <= (i_start && !i_mode) ? RUN : (i_step && i_mode) ? STEP : IDLE;
                RUN: state <= halt_ok ? DRAIN : RUN;
                STEP: state <= halt_ok ? DRAIN : IDLE;
                DRAIN: begin
                    drain_cnt <= (drain_cnt == 2'(DRAIN_LEN - 1)) ? 2'd0 : drain_cnt + 2'd1;
                    state <= (drain_cnt == 2'(DRAIN_LEN - 1)) ? HALTED : DRAIN;
                end
                HALTED: state <= HALTED;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed stimulus against a phase-level behavioural model of pipeline_ctrl
module tb_pipeline_ctrl;
    localparam int RB = 5;
    localparam int CB = 5;
    localparam longint MAXC = (64'd1 << CB) - 1;

    logic i_clk = 0, i_rst = 1, i_start = 0, i_mode = 0, i_step = 0;
    logic [RB-1:0] ID_rs = 0, ID_rt = 0, EX_rt = 0;
    logic EX_memread = 0, EX_branch_taken = 0, ID_halt = 0;
    logic o_pc_en, o_ifid_en, o_idex_en, o_exmem_en, o_memwb_en;
    logic o_ifid_flush, o_idex_flush, o_halted;
    logic [CB-1:0] o_cycle_cnt, o_stall_cnt;

    int passed = 0, total = 0;
    int ph = 0, drain_left = 0;
    longint m_cyc = 0, m_stall = 0;

    always #5 i_clk = ~i_clk;

    pipeline_ctrl #(.RBITS(RB), .CBITS(CB)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_mode(i_mode), .i_step(i_step),
        .ID_rs(ID_rs), .ID_rt(ID_rt), .EX_rt(EX_rt), .EX_memread(EX_memread),
        .EX_branch_taken(EX_branch_taken), .ID_halt(ID_halt),
        .o_pc_en(o_pc_en), .o_ifid_en(o_ifid_en), .o_idex_en(o_idex_en),
        .o_exmem_en(o_exmem_en), .o_memwb_en(o_memwb_en),
        .o_ifid_flush(o_ifid_flush), .o_idex_flush(o_idex_flush), .o_halted(o_halted),
        .o_cycle_cnt(o_cycle_cnt), .o_stall_cnt(o_stall_cnt)
    );

    // ph: 0 idle, 1 run, 2 step, 3 drain, 4 halted
    function automatic logic raw_lu();
        return EX_memread && EX_rt != 0 && (EX_rt == ID_rs || EX_rt == ID_rt);
    endfunction

    function automatic logic halt_now();
        return ID_halt && !EX_branch_taken && !raw_lu();
    endfunction

    // {pc, ifid, idex, exmem, memwb, ifid_flush, idex_flush, halted}
    function automatic logic [7:0] m_out();
        if (i_rst || ph == 0) return 8'b00000000;
        if (ph == 4) return 8'b00000001;
        if (ph == 3) return 8'b00111000;
        if (EX_branch_taken) return 8'b11111110;
        if (raw_lu()) return 8'b00111010;
        if (ID_halt) return 8'b01111100;
        return 8'b11111000;
    endfunction

    always @(posedge i_clk) begin
        if (i_rst) begin
            ph <= 0;
            drain_left <= 0;
            m_cyc <= 0;
            m_stall <= 0;
        end else begin
            if (ph >= 1 && ph <= 3) m_cyc <= (m_cyc < MAXC) ? m_cyc + 1 : MAXC;
            if ((ph == 1 || ph == 2) && raw_lu() && !EX_branch_taken)
                m_stall <= (m_stall < MAXC) ? m_stall + 1 : MAXC;
            if (ph == 0) ph <= (i_start && !i_mode) ? 1 : (i_step && i_mode) ? 2 : 0;
            else if (ph == 1 || ph == 2) begin
                if (halt_now()) begin
                    ph <= 3;
                    drain_left <= 3;
                end else if (ph == 2) ph <= 0;
            end else if (ph == 3) begin
                drain_left <= drain_left - 1;
                if (drain_left == 1) ph <= 4;
            end
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    always begin
        @(negedge i_clk);
        check("outputs", {o_pc_en, o_ifid_en, o_idex_en, o_exmem_en, o_memwb_en,
                          o_ifid_flush, o_idex_flush, o_halted}, m_out());
        check("cycle_cnt", o_cycle_cnt, m_cyc);
        check("stall_cnt", o_stall_cnt, m_stall);
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic neg();
        @(negedge i_clk);
    endtask

    task automatic clr();
        EX_memread = 0; EX_rt = 0; ID_rs = 0; ID_rt = 0; EX_branch_taken = 0; ID_halt = 0;
        i_start = 0; i_step = 0;
    endtask

    initial begin
        i_rst = 1;
        tick(); tick();
        i_rst = 0; i_mode = 0; i_start = 1;
        neg();
        check("rst_cyc", o_cycle_cnt, 0);
        check("rst_halted", o_halted, 0);
        check("idle_pc_en", o_pc_en, 0);
        tick(); i_start = 0;
        neg();
        check("run_en", {o_pc_en, o_ifid_en, o_idex_en, o_exmem_en, o_memwb_en}, 5'b11111);
        tick(); EX_memread = 1; EX_rt = 8; ID_rs = 8;
        neg();
        check("first_cyc", o_cycle_cnt, 1);
        check("lu_pc_ifid", {o_pc_en, o_ifid_en, o_idex_en}, 3'b001);
        check("lu_idex_flush", o_idex_flush, 1);
        tick(); EX_rt = 0; ID_rs = 0;
        neg();
        check("stall_one", o_stall_cnt, 1);
        check("r0_no_stall", {o_pc_en, o_idex_flush}, 2'b10);
        tick(); EX_rt = 3; ID_rt = 3;
        neg();
        check("rt_stall", {o_pc_en, o_idex_flush}, 2'b01);
        tick(); EX_rt = 8; ID_rs = 8; ID_rt = 0; EX_branch_taken = 1; ID_halt = 1;
        neg();
        check("br_flush", {o_ifid_flush, o_idex_flush, o_pc_en}, 3'b111);
        tick(); clr();
        neg();
        check("br_stays_run", o_pc_en, 1);
        check("br_no_stall", o_stall_cnt, 2);
        tick(); ID_halt = 1;
        neg();
        check("halt_acc", {o_pc_en, o_ifid_flush}, 2'b01);
        tick(); clr(); EX_branch_taken = 1; EX_memread = 1; EX_rt = 8; ID_rs = 8;
        repeat (3) begin
            neg();
            check("drain_en", {o_pc_en, o_ifid_en, o_memwb_en, o_ifid_flush, o_idex_flush}, 5'b00100);
            tick();
        end
        clr(); i_start = 1; i_step = 1;
        repeat (3) begin
            neg();
            check("halted", {o_halted, o_pc_en, o_memwb_en}, 3'b100);
            tick();
        end
        neg();
        check("halt_cyc", o_cycle_cnt, 10);

        clr(); i_rst = 1;
        tick(); i_rst = 0; i_mode = 1;
        neg();
        check("rst_from_halted", {o_halted, o_cycle_cnt}, 0);
        tick(); i_step = 1;
        neg();
        check("idle_step_en", o_pc_en, 0);
        tick(); i_step = 0;
        neg();
        check("step_en", o_pc_en, 1);
        tick();
        neg();
        check("step_back_idle", o_pc_en, 0);
        check("step_cyc1", o_cycle_cnt, 1);
        tick(); tick(); i_step = 1;
        neg();
        tick(); i_step = 0;
        neg();
        check("step_en2", o_memwb_en, 1);
        tick();
        neg();
        check("step_cyc2", o_cycle_cnt, 2);
        check("step_idle2", o_memwb_en, 0);
        tick(); i_step = 1;
        tick(); i_step = 0; ID_halt = 1;
        neg();
        check("step_halt", {o_pc_en, o_ifid_flush}, 2'b01);
        tick(); ID_halt = 0;
        neg();
        check("step_to_drain", {o_pc_en, o_memwb_en}, 2'b01);
        tick(); i_rst = 1;
        neg();
        check("rst_gates_out", o_memwb_en, 0);
        tick(); i_rst = 0;
        neg();
        check("rst_mid_drain", {o_halted, o_memwb_en, o_cycle_cnt, o_stall_cnt}, 0);

        i_mode = 0; i_start = 1;
        tick(); i_start = 0; EX_memread = 1; EX_rt = 8; ID_rs = 8;
        repeat (35) tick();
        neg();
        check("sat_cyc", o_cycle_cnt, 31);
        check("sat_stall", o_stall_cnt, 31);
        i_rst = 1;
        tick(); i_rst = 0; clr();
        neg();
        check("rst_mid_stall", {o_stall_cnt, o_cycle_cnt}, 0);
        i_start = 1; i_step = 1;
        tick(); clr();
        neg();
        check("start_step_run", o_pc_en, 1);
        ID_halt = 1;
        tick(); ID_halt = 0;
        repeat (3) tick();
        neg();
        check("redrain_halted", o_halted, 1);
        check("redrain_cyc", o_cycle_cnt, 4);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter RBITS, default 5, register-index width.
REQ-002 Parameter CBITS, default 32, width of the performance counters.
REQ-003 i_clk  input  1  single clock; all state updates on its rising edge.
REQ-004 i_rst  input  1  synchronous active-high reset, sampled on the i_clk rising edge.
REQ-005 i_start  input  1  level; begins continuous run from IDLE when i_mode=0.
REQ-006 i_mode  input  1  0=continuous, 1=single-step; sampled only in IDLE.
REQ-007 i_step  input  1  one-cycle pulse; advances the pipeline one cycle when in IDLE with i_mode=1.
REQ-008 ID_rs, ID_rt  input  RBITS  source registers of the instruction in ID.
REQ-009 EX_rt  input  RBITS  destination of the instruction in EX; EX_memread  input  1  EX instruction is a load.
REQ-010 EX_branch_taken  input  1  taken branch/jump resolved in EX.
REQ-011 ID_halt  input  1  instruction in ID is HALT.
REQ-012 o_pc_en, o_ifid_en, o_idex_en, o_exmem_en, o_memwb_en  output  1 each  pipeline register write enables.
REQ-013 o_ifid_flush, o_idex_flush  output  1 each  load a bubble (all controls zero) into IF/ID or ID/EX.
REQ-014 o_halted  output  1  program finished and pipeline drained.
REQ-015 o_cycle_cnt, o_stall_cnt  output  CBITS each  active-cycle count; load-use stall count.

Function
REQ-016 States: IDLE, RUN, STEP, DRAIN, HALTED; outputs are combinational from state plus hazard inputs.
REQ-017 IDLE: all enables and flushes 0; i_start&~i_mode -> RUN; i_step&i_mode -> STEP; i_start and i_step together with i_mode=0 -> RUN.
REQ-018 STEP: exactly one active cycle with RUN output rules, then -> IDLE (-> DRAIN if ID_halt accepted that cycle).
REQ-019 RUN: all enables 1 unless a hazard rule below applies; stays in RUN until a HALT is accepted.
REQ-020 Load-use hazard: EX_memread & EX_rt!=0 & (EX_rt==ID_rs | EX_rt==ID_rt) -> o_pc_en=0, o_ifid_en=0, o_idex_flush=1; all other enables 1.
REQ-021 Taken branch: EX_branch_taken -> o_ifid_flush=1, o_idex_flush=1, o_pc_en=1; overrides load-use and halt in the same cycle.
REQ-022 HALT accepted when ID_halt=1 in RUN/STEP with no load-use hazard and no taken branch: o_pc_en=0, o_ifid_flush=1, next state DRAIN.
REQ-023 DRAIN: o_pc_en=0, o_ifid_en=0, o_idex_en/o_exmem_en/o_memwb_en=1 for exactly 3 cycles (2-bit counter 0..2), then -> HALTED.
REQ-024 HALTED: all enables 0, o_halted=1; remains until i_rst; i_start/i_step ignored.
REQ-025 o_cycle_cnt increments by 1 on every cycle spent in RUN, STEP or DRAIN.
REQ-026 o_stall_cnt increments by 1 on every cycle the REQ-020 stall is applied and REQ-021 is not asserted.
REQ-027 Both counters saturate at 2^CBITS-1; no wrap.
REQ-028 In DRAIN and HALTED, hazard inputs are ignored.

Reset
REQ-029 i_rst=1 -> state IDLE, drain counter 0, both counters 0, o_halted=0, all enables/flushes 0, from any state including mid-DRAIN and mid-stall.
REQ-030 Reset has priority over every other input in the same cycle.

Structure
REQ-031 State encodings and the drain length constant (3) live in the shared CPU package; RBITS/CBITS defaults come from it.
REQ-032 One sub-module, hazard_detect: purely combinational load-use comparison (REQ-020), instantiated once.

Verification
REQ-033 Reset, i_mode=0, i_start=1 -> RUN next cycle; all enables 1; o_cycle_cnt=1 after first RUN cycle.
REQ-034 RUN, EX_memread=1, EX_rt=8, ID_rs=8 for one cycle -> o_pc_en=0, o_ifid_en=0, o_idex_flush=1; o_stall_cnt=1; EX_rt=0 with ID_rs=0 -> no stall.
REQ-035 RUN, EX_branch_taken=1 with simultaneous load-use and ID_halt=1 -> both flushes 1, o_pc_en=1, state stays RUN, o_stall_cnt unchanged.
REQ-036 RUN, ID_halt=1 -> 3 DRAIN cycles (o_memwb_en=1, o_pc_en=0), then o_halted=1 forever; o_cycle_cnt = RUN cycles + 3.
REQ-037 i_mode=1: two i_step pulses 4 cycles apart -> exactly two single active cycles, IDLE between; o_cycle_cnt=2.
REQ-038 i_rst asserted on second DRAIN cycle -> next cycle IDLE, counters 0, o_halted=0.
